pop_seq: RTL and testbench

- Micro-sequencer that executes the memory half of the SM83 "POP qq" instruction (opcodes C1/D1/E1/F1), the read-side counterpart of PUSH.
- Started by the decoder after the M1 fetch. It owns the address bus and read strobe for M2 and M3, and reads the low byte then the high byte from the stack. It increments SP after each read and writes the assembled 16-bit value into BC/DE/HL/AF.
- Sits between the CPU decoder, the register file and the bus interface.

---
 rtl/pop_seq_pkg.sv | 11 +
 rtl/pop_seq_if.sv | 21 ++
 rtl/pop_seq_tcnt.sv | 24 ++
 rtl/pop_seq.sv | 63 ++++++
 tb/tb_pop_seq.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/pop_seq_pkg.sv
// pop_seq_pkg: shared types and constants for the POP qq micro-sequencer
package pop_seq_pkg;
  typedef enum logic [1:0] {R_BC, R_DE, R_HL, R_AF} reg16_e;
  typedef enum logic [1:0] {T1, T2, T3, T4} tphase_e;
  typedef enum logic [1:0] {S_IDLE, S_RD_LO, S_RD_HI} state_e;
  localparam logic [7:0] F_MASK = 8'hF0;
  localparam logic [7:0] POP_OPC = 8'hC1;
  function automatic logic [15:0] pop_value(input logic [7:0] hi, input logic [7:0] lo, input logic [1:0] sel);
    return {hi, reg16_e'(sel) == R_AF ? lo & F_MASK : lo};
  endfunction
endpackage

// File: rtl/pop_seq_if.sv
// pop_seq_if: decoder/register-file/bus signals of the POP sequencer
interface pop_seq_if;
  logic        start;
  logic [1:0]  dst_reg;
  logic [15:0] sp_in;
  logic [7:0]  din;
  logic [15:0] adr;
  logic        adr_oe;
  logic        rd;
  logic [15:0] sp_out;
  logic        sp_we;
  logic [15:0] reg_out;
  logic [1:0]  reg_sel;
  logic        reg_we;
  logic        busy;
  logic        done;
  modport slave(input start, dst_reg, sp_in, din,
                output adr, adr_oe, rd, sp_out, sp_we, reg_out, reg_sel, reg_we, busy, done);
  modport master(output start, dst_reg, sp_in, din,
                 input adr, adr_oe, rd, sp_out, sp_we, reg_out, reg_sel, reg_we, busy, done);
endinterface

// File: rtl/pop_seq_tcnt.sv
// pop_seq_tcnt: T-phase counter inside one machine cycle
module pop_tcnt
  import pop_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    clr,
  input  logic    en,
  output tphase_e t,
  output logic    t_last,
  output logic    t_sample
);
  logic [1:0] cnt;
  assign t = tphase_e'(cnt);
  assign t_last = cnt == 2'(N - 1);
  assign t_sample = cnt == 2'(N - 2);
  // restart at T1 on an accepted start, otherwise step and wrap each machine cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= t_last ? 2'd0 : cnt + 2'd1;
endmodule

// File: rtl/pop_seq.sv
// pop_seq: memory half of SM83 POP qq, two stack reads then a register-pair write
module pop_seq
  import pop_seq_pkg::*;
#(
  parameter int TCYC_PER_MCYC = 4
) (
  input logic       clk,
  input logic       reset,
  pop_seq_if.slave  bus
);
  state_e state_q, state_d;
  tphase_e t;
  logic [15:0] sp_q, sp_out_q, reg_out_q, val;
  logic [7:0] lo_q, hi_q;
  logic [1:0] sel_q;
  logic active, t_last, t_sample, m_end, fin, accept;
  assign active = state_q != S_IDLE;
  assign m_end = active && t_last;
  assign fin = state_q == S_RD_HI && t_last;
  assign accept = bus.start && (!active || fin);
  assign val = pop_value(hi_q, lo_q, sel_q);
  pop_tcnt #(.N(TCYC_PER_MCYC)) u_tcnt (
    .clk(clk), .reset(reset), .clr(accept), .en(active),
    .t(t), .t_last(t_last), .t_sample(t_sample)
  );
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= S_IDLE;
    else state_q <= state_d;
  // next state and bus/strobe outputs; a start coinciding with done chains directly
  always_comb begin
    state_d = accept ? S_RD_LO : (state_q == S_RD_LO && t_last) ? S_RD_HI : fin ? S_IDLE : state_q;
    bus.adr = sp_q;
    bus.adr_oe = active;
    bus.busy = active;
    bus.rd = active && t != T4;
    bus.sp_we = m_end;
    bus.sp_out = m_end ? sp_q + 16'd1 : sp_out_q;
    bus.reg_we = fin;
    bus.done = fin;
    bus.reg_out = fin ? val : reg_out_q;
    bus.reg_sel = sel_q;
  end
  // datapath: latch operands on start, step SP after the low read, capture bytes at end of T3
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sp_q <= '0;
      sel_q <= '0;
      lo_q <= '0;
      hi_q <= '0;
      sp_out_q <= '0;
      reg_out_q <= '0;
    end else begin
      if (accept) begin
        sp_q <= bus.sp_in;
        sel_q <= bus.dst_reg;
      end else if (state_q == S_RD_LO && t_last) sp_q <= sp_q + 16'd1;
      if (state_q == S_RD_LO && t_sample) lo_q <= bus.din;
      if (state_q == S_RD_HI && t_sample) hi_q <= bus.din;
      if (m_end) sp_out_q <= sp_q + 16'd1;
      if (fin) reg_out_q <= val;
    end
endmodule

// File: tb/tb_pop_seq.sv
// tb_pop_seq: randomized and directed checks of pop_seq against a cycle-position reference
module tb_pop_seq;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  pop_seq_if bif();
  pop_seq #(.TCYC_PER_MCYC(4)) dut (.clk(clk), .reset(reset), .bus(bif));
  logic [7:0] mem [0:65535];
  assign bif.din = mem[bif.adr];
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_val(input logic [15:0] s, input logic [1:0] d);
    logic [15:0] s1;
    s1 = s + 16'd1;
    return {mem[s1], d == 2'd3 ? (mem[s] & 8'hF0) : mem[s]};
  endfunction

  task automatic zero_chk(input string tag);
    check({tag, "_adr"}, bif.adr, 0);
    check({tag, "_adr_oe"}, bif.adr_oe, 0);
    check({tag, "_rd"}, bif.rd, 0);
    check({tag, "_busy"}, bif.busy, 0);
    check({tag, "_done"}, bif.done, 0);
    check({tag, "_sp_we"}, bif.sp_we, 0);
    check({tag, "_reg_we"}, bif.reg_we, 0);
    check({tag, "_sp_out"}, bif.sp_out, 0);
    check({tag, "_reg_out"}, bif.reg_out, 0);
    check({tag, "_reg_sel"}, bif.reg_sel, 0);
  endtask

  task automatic issue(input logic [15:0] s, input logic [1:0] d);
    @(negedge clk);
    bif.start = 1;
    bif.dst_reg = d;
    bif.sp_in = s;
    @(posedge clk);
    #1;
    bif.start = 0;
    bif.sp_in = 16'($urandom);
    bif.dst_reg = 2'($urandom);
  endtask

  task automatic run_pop(input logic [15:0] s, input logic [1:0] d, input int inj, input int abort,
                         input bit chain, input logic [15:0] ns, input logic [1:0] nd);
    logic [15:0] s1, s2, ea;
    int ph;
    s1 = s + 16'd1;
    s2 = s + 16'd2;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      ea = c > 4 ? s1 : s;
      ph = (c - 1) % 4;
      if (c == abort) begin
        reset = 1;
        #1;
        zero_chk("abort");
        return;
      end
      check("adr", bif.adr, ea);
      check("adr_oe", bif.adr_oe, 1);
      check("busy", bif.busy, 1);
      check("rd", bif.rd, ph != 3);
      check("sp_we", bif.sp_we, ph == 3);
      if (ph == 3) check("sp_out", bif.sp_out, c > 4 ? s2 : s1);
      check("done", bif.done, c == 8);
      check("reg_we", bif.reg_we, c == 8);
      if (c == 8) begin
        check("reg_out", bif.reg_out, ref_val(s, d));
        check("reg_sel", bif.reg_sel, d);
      end
      if (c == inj || (c == 8 && chain)) begin
        bif.start = 1;
        bif.dst_reg = (c == 8 && chain) ? nd : ~d;
        bif.sp_in = (c == 8 && chain) ? ns : ~s;
      end
      @(posedge clk);
      #1;
      bif.start = 0;
      bif.sp_in = 16'($urandom);
      bif.dst_reg = 2'($urandom);
    end
  endtask

  task automatic idle_chk(input logic [15:0] last_adr);
    @(negedge clk);
    check("idle_busy", bif.busy, 0);
    check("idle_adr_oe", bif.adr_oe, 0);
    check("idle_rd", bif.rd, 0);
    check("idle_done", bif.done, 0);
    check("idle_adr", bif.adr, last_adr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s, ns;
    logic [1:0] d, nd;
    bit pend, ch;
    int inj;
    bif.start = 0;
    bif.dst_reg = 0;
    bif.sp_in = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    zero_chk("reset");
    reset = 0;
    mem[16'hC000] = 8'h34;
    mem[16'hC001] = 8'h12;
    issue(16'hC000, 2'd0);
    run_pop(16'hC000, 2'd0, 0, 0, 0, 0, 0);
    check("bc_value", dut.reg_out_q, 16'h1234);
    idle_chk(16'hC001);
    mem[16'hD000] = 8'hFF;
    mem[16'hD001] = 8'hAB;
    issue(16'hD000, 2'd3);
    run_pop(16'hD000, 2'd3, 0, 0, 0, 0, 0);
    check("af_value", dut.reg_out_q, 16'hABF0);
    idle_chk(16'hD001);
    mem[16'hFFFF] = 8'h11;
    mem[16'h0000] = 8'h22;
    issue(16'hFFFF, 2'd2);
    run_pop(16'hFFFF, 2'd2, 0, 0, 0, 0, 0);
    check("wrap_value", dut.reg_out_q, 16'h2211);
    check("wrap_sp", dut.sp_out_q, 16'h0001);
    idle_chk(16'h0000);
    issue(16'hC000, 2'd1);
    run_pop(16'hC000, 2'd1, 0, 0, 1, 16'hC002, 2'd2);
    run_pop(16'hC002, 2'd2, 0, 0, 0, 0, 0);
    check("b2b_sp", dut.sp_out_q, 16'hC004);
    idle_chk(16'hC003);
    issue(16'hE000, 2'd0);
    run_pop(16'hE000, 2'd0, 0, 6, 0, 0, 0);
    @(posedge clk);
    #1;
    zero_chk("held");
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_busy", bif.busy, 0);
      check("post_rst_sp_we", bif.sp_we, 0);
      check("post_rst_reg_we", bif.reg_we, 0);
    end
    issue(16'hE000, 2'd0);
    run_pop(16'hE000, 2'd0, 0, 0, 0, 0, 0);
    idle_chk(16'hE001);
    issue(16'hB000, 2'd2);
    run_pop(16'hB000, 2'd2, 3, 0, 0, 0, 0);
    idle_chk(16'hB001);
    s = 16'($urandom);
    d = 2'($urandom);
    pend = 0;
    for (int i = 0; i < 20; i++) begin
      if (!pend) issue(s, d);
      ns = 16'($urandom);
      nd = 2'($urandom);
      ch = (i < 19) && ($urandom_range(1) == 1);
      inj = $urandom_range(0, 7);
      run_pop(s, d, inj, 0, ch, ns, nd);
      if (!ch) idle_chk(s + 16'd1);
      s = ns;
      d = nd;
      pend = ch;
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
